// File: rtl/sim_axi_mem_pkg.sv
// sim_axi_mem shared types, response codes and the
// host-side pmem backing store behind dci_pmem_read/dci_pmem_write.
package sim_axi_mem_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_WAIT = 2'd1,
    RD_RESP = 2'd2
  } rd_state_e;

  logic [63:0] g_mem [logic [63:0]];
  int unsigned g_rd_cnt;
  int unsigned g_wr_cnt;

  // Unwritten locations read back a fixed address-derived pattern
  function automatic logic [63:0] pmem_seed(
    input logic [63:0] a
  );
    return {a[31:0] ^ 32'hDEAD_BEEF, a[31:0]};
  endfunction

  function automatic logic [63:0] pmem_peek(
    input logic [63:0] a
  );
    if (g_mem.exists(a) != 0) return g_mem[a];
    return pmem_seed(a);
  endfunction

  function automatic logic [63:0] dci_pmem_read(
    input logic [63:0] addr
  );
    g_rd_cnt++;
    return pmem_peek(addr);
  endfunction

  function automatic void dci_pmem_write(
    input logic [63:0] addr,
    input logic [63:0] data,
    input logic [7:0]  strb
  );
    logic [63:0] v;
    g_wr_cnt++;
    v = pmem_peek(addr);
    for (int i = 0; i < 8; i++) begin
      if (strb[i]) v[i*8 +: 8] = data[i*8 +: 8];
    end
    g_mem[addr] = v;
  endfunction

endpackage

// File: rtl/sim_axi_mem_rdq.sv
// sim_axi_mem read-request queue.
// Synchronous FIFO with full/empty flags, no push bypass.
module sim_axi_mem_rdq #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LP_FULL = (AW+1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [AW:0]   r_cnt;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_cnt == LP_FULL);
  assign o_empty = (r_cnt == '0);
  assign o_data  = r_mem[r_rp];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= i_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/sim_axi_mem.sv
// sim_axi_mem: AXI-lite style simulation memory over dci_pmem.
// Define SIM_AXI_MEM_TRACE_EN to print one line per pmem access.
module sim_axi_mem
  import sim_axi_mem_pkg::*;
#(
  parameter int          ADDR_W   = 32,
  parameter int          DATA_W   = 64,
  parameter int          RD_LAT   = 1,
  parameter int          RQ_DEPTH = 4,
  parameter logic [63:0] MEM_BASE = 64'h8000_0000,
  parameter logic [63:0] MEM_SIZE = 64'h0800_0000
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic [63:0]         pc,
  input  logic [ADDR_W-1:0]   araddr,
  input  logic                arvalid,
  output logic                arready,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          rresp,
  output logic                rvalid,
  input  logic                rready,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic                awvalid,
  output logic                awready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wvalid,
  output logic                wready,
  output logic [1:0]          bresp,
  output logic                bvalid,
  input  logic                bready
);

  localparam int SW = DATA_W / 8;
  localparam logic [63:0] LP_ALIGN = ~64'(SW - 1);
  localparam logic [64:0] LP_LO = {1'b0, MEM_BASE};
  localparam logic [64:0] LP_HI = LP_LO + {1'b0, MEM_SIZE};
  localparam logic [3:0]  LP_WAIT =
    (RD_LAT > 1) ? 4'(RD_LAT - 2) : 4'd0;

  logic              r_live;
  rd_state_e         r_state;
  logic [3:0]        r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_rdata;
  logic [1:0]        r_rresp;
  logic              r_rvalid;

  logic              r_aw_held;
  logic [ADDR_W-1:0] r_awaddr;
  logic              r_w_held;
  logic [DATA_W-1:0] r_wdata;
  logic [SW-1:0]     r_wstrb;
  logic              r_bvalid;
  logic [1:0]        r_bresp;

  logic              w_q_full;
  logic              w_q_empty;
  logic [ADDR_W-1:0] w_q_data;
  logic              w_push;
  logic              w_pop;
  logic              w_fire;
  logic              w_unused_pc;

  function automatic logic f_hit(
    input logic [ADDR_W-1:0] a
  );
    logic [64:0] w_a;
    w_a = 65'(a);
    return (w_a >= LP_LO) && (w_a < LP_HI);
  endfunction

  function automatic logic [63:0] f_align(
    input logic [ADDR_W-1:0] a
  );
    return 64'(a) & LP_ALIGN;
  endfunction

  function automatic logic [DATA_W+1:0] f_read(
    input logic [ADDR_W-1:0] a
  );
    logic [63:0] w_d;
    if (f_hit(a)) begin
      w_d = dci_pmem_read(f_align(a));
`ifdef SIM_AXI_MEM_TRACE_EN
      $display("R pc=%h addr=%h data=%h strb=%h resp=%b",
        pc, f_align(a), w_d, 8'hFF, RESP_OKAY);
`endif
      return {RESP_OKAY, w_d[DATA_W-1:0]};
    end
    return {RESP_DECERR, {DATA_W{1'b0}}};
  endfunction

  function automatic logic [1:0] f_write(
    input logic [ADDR_W-1:0] a,
    input logic [DATA_W-1:0] d,
    input logic [SW-1:0]     s
  );
    if (f_hit(a)) begin
      dci_pmem_write(f_align(a), 64'(d), 8'(s));
`ifdef SIM_AXI_MEM_TRACE_EN
      $display("W pc=%h addr=%h data=%h strb=%h resp=%b",
        pc, f_align(a), 64'(d), 8'(s), RESP_OKAY);
`endif
      return RESP_OKAY;
    end
    return RESP_DECERR;
  endfunction

  assign w_unused_pc = ^pc;

  assign arready = r_live && !w_q_full;
  assign awready = r_live && !r_aw_held;
  assign wready  = r_live && !r_w_held;
  assign rdata   = r_rdata;
  assign rresp   = r_rresp;
  assign rvalid  = r_rvalid;
  assign bresp   = r_bresp;
  assign bvalid  = r_bvalid;

  assign w_push = arvalid && arready;
  assign w_pop  = !w_q_empty &&
                  ((r_state == RD_IDLE) ||
                   (r_state == RD_RESP && rready));
  assign w_fire = r_aw_held && r_w_held && !r_bvalid;

  sim_axi_mem_rdq #(
    .W     (ADDR_W),
    .DEPTH (RQ_DEPTH)
  ) u_rdq (
    .clk     (aclk),
    .rst_n   (aresetn),
    .i_push  (w_push),
    .i_data  (araddr),
    .i_pop   (w_pop),
    .o_data  (w_q_data),
    .o_full  (w_q_full),
    .o_empty (w_q_empty)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_live <= 1'b0;
    else          r_live <= 1'b1;
  end

  // A pop from RD_RESP chains straight into the next request
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state  <= RD_IDLE;
      r_cnt    <= '0;
      r_addr   <= '0;
      r_rdata  <= '0;
      r_rresp  <= RESP_OKAY;
      r_rvalid <= 1'b0;
    end else begin
      unique case (1'b1)
        w_pop: begin
          if (RD_LAT == 1) begin
            r_state  <= RD_RESP;
            {r_rresp, r_rdata} <= f_read(w_q_data);
            r_rvalid <= 1'b1;
          end else begin
            r_state  <= RD_WAIT;
            r_addr   <= w_q_data;
            r_cnt    <= LP_WAIT;
            r_rvalid <= 1'b0;
          end
        end
        (r_state == RD_WAIT): begin
          if (r_cnt == 4'd0) begin
            r_state  <= RD_RESP;
            {r_rresp, r_rdata} <= f_read(r_addr);
            r_rvalid <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        (r_state == RD_RESP && rready && w_q_empty): begin
          r_state  <= RD_IDLE;
          r_rvalid <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_aw_held <= 1'b0;
      r_awaddr  <= '0;
      r_w_held  <= 1'b0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
    end else begin
      if (w_fire) begin
        r_bresp   <= f_write(r_awaddr, r_wdata, r_wstrb);
        r_bvalid  <= 1'b1;
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
      end else if (r_bvalid && bready) begin
        r_bvalid <= 1'b0;
      end
      if (awvalid && awready) begin
        r_aw_held <= 1'b1;
        r_awaddr  <= awaddr;
      end
      if (wvalid && wready) begin
        r_w_held <= 1'b1;
        r_wdata  <= wdata;
        r_wstrb  <= wstrb;
      end
    end
  end

endmodule

// File: tb/tb_sim_axi_mem.sv
// Directed bench for sim_axi_mem (RD_LAT=3, RQ_DEPTH=4).
// Inputs change and outputs are sampled on the falling edge.
module tb_sim_axi_mem;
  import sim_axi_mem_pkg::*;

  logic        aclk;
  logic        aresetn;
  logic [63:0] pc;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  int n_cmp;
  int n_bad;

  sim_axi_mem #(
    .ADDR_W   (32),
    .DATA_W   (64),
    .RD_LAT   (3),
    .RQ_DEPTH (4)
  ) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .pc      (pc),
    .araddr  (araddr),
    .arvalid (arvalid),
    .arready (arready),
    .rdata   (rdata),
    .rresp   (rresp),
    .rvalid  (rvalid),
    .rready  (rready),
    .awaddr  (awaddr),
    .awvalid (awvalid),
    .awready (awready),
    .wdata   (wdata),
    .wstrb   (wstrb),
    .wvalid  (wvalid),
    .wready  (wready),
    .bresp   (bresp),
    .bvalid  (bvalid),
    .bready  (bready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] seed(input logic [31:0] a);
    return {a ^ 32'hDEAD_BEEF, a};
  endfunction

  task automatic rd_chk(
    input string       tag,
    input logic [31:0] a,
    input logic [63:0] ed,
    input logic [1:0]  er
  );
    int   k;
    logic got;
    @(negedge aclk);
    chk({tag, ".arready"}, 64'(arready), 64'd1);
    araddr  = a;
    arvalid = 1'b1;
    rready  = 1'b1;
    @(negedge aclk);
    arvalid = 1'b0;
    k   = 0;
    got = 1'b0;
    while (!got && k < 20) begin
      if (rvalid) got = 1'b1;
      else begin
        @(negedge aclk);
        k++;
      end
    end
    chk({tag, ".seen"}, 64'(got), 64'd1);
    chk({tag, ".lat"}, 64'(k), 64'd3);
    chk({tag, ".data"}, rdata, ed);
    chk({tag, ".resp"}, 64'(rresp), 64'(er));
    @(negedge aclk);
    rready = 1'b0;
  endtask

  task automatic wr_chk(
    input string       tag,
    input logic [31:0] a,
    input logic [63:0] d,
    input logic [7:0]  s,
    input logic [1:0]  er
  );
    @(negedge aclk);
    awaddr  = a;
    awvalid = 1'b1;
    wdata   = d;
    wstrb   = s;
    wvalid  = 1'b1;
    bready  = 1'b0;
    @(negedge aclk);
    awvalid = 1'b0;
    wvalid  = 1'b0;
    chk({tag, ".b_early"}, 64'(bvalid), 64'd0);
    @(negedge aclk);
    chk({tag, ".bvalid"}, 64'(bvalid), 64'd1);
    chk({tag, ".bresp"}, 64'(bresp), 64'(er));
    bready = 1'b1;
    @(negedge aclk);
    bready = 1'b0;
    chk({tag, ".b_done"}, 64'(bvalid), 64'd0);
  endtask

  initial begin
    int unsigned base;
    logic [31:0] qa [6];
    int          n_acc;
    int          n_rsp;
    logic        lo_seen;
    logic        ar_f;
    logic        seen;

    n_cmp   = 0;
    n_bad   = 0;
    aresetn = 1'b0;
    pc      = 64'h0000_0000_8000_1000;
    araddr  = '0;
    arvalid = 1'b0;
    rready  = 1'b0;
    awaddr  = '0;
    awvalid = 1'b0;
    wdata   = '0;
    wstrb   = '0;
    wvalid  = 1'b0;
    bready  = 1'b0;

    repeat (3) @(negedge aclk);
    chk("rst.rvalid", 64'(rvalid), 64'd0);
    chk("rst.bvalid", 64'(bvalid), 64'd0);
    chk("rst.rresp", 64'(rresp), 64'd0);
    chk("rst.bresp", 64'(bresp), 64'd0);
    chk("rst.rdata", rdata, 64'd0);
    chk("rst.arready", 64'(arready), 64'd0);
    chk("rst.awready", 64'(awready), 64'd0);
    chk("rst.wready", 64'(wready), 64'd0);
    aresetn = 1'b1;
    @(negedge aclk);
    chk("rel.arready", 64'(arready), 64'd1);
    chk("rel.awready", 64'(awready), 64'd1);
    chk("rel.wready", 64'(wready), 64'd1);

    base = g_rd_cnt;
    rd_chk("rd_lat3", 32'h8000_0010,
      64'h5EAD_BEFF_8000_0010, 2'b00);
    chk("rd_lat3.dpi", 64'(g_rd_cnt - base), 64'd1);

    base = g_rd_cnt;
    rd_chk("rd_decerr", 32'h0000_0000, 64'd0, 2'b11);
    chk("rd_decerr.dpi", 64'(g_rd_cnt - base), 64'd0);

    base = g_wr_cnt;
    @(negedge aclk);
    awaddr  = 32'h8000_0100;
    awvalid = 1'b1;
    @(negedge aclk);
    awvalid = 1'b0;
    chk("wr_stag.aw_held", 64'(awready), 64'd0);
    @(negedge aclk);
    wdata  = 64'h1122_3344_5566_7788;
    wstrb  = 8'h0F;
    wvalid = 1'b1;
    @(negedge aclk);
    wvalid = 1'b0;
    chk("wr_stag.b_early", 64'(bvalid), 64'd0);
    @(negedge aclk);
    chk("wr_stag.bvalid", 64'(bvalid), 64'd1);
    chk("wr_stag.bresp", 64'(bresp), 64'd0);
    chk("wr_stag.dpi", 64'(g_wr_cnt - base), 64'd1);
    bready = 1'b1;
    @(negedge aclk);
    bready = 1'b0;
    chk("wr_stag.b_done", 64'(bvalid), 64'd0);
    rd_chk("wr_stag.rb", 32'h8000_0100,
      64'h5EAD_BFEF_5566_7788, 2'b00);

    base = g_wr_cnt;
    wr_chk("wr_decerr", 32'h0000_0000,
      64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 2'b11);
    chk("wr_decerr.dpi", 64'(g_wr_cnt - base), 64'd0);

    wr_chk("wr_both", 32'h8000_0400,
      64'h0123_4567_89AB_CDEF, 8'hFF, 2'b00);
    rd_chk("wr_both.rb", 32'h8000_0400,
      64'h0123_4567_89AB_CDEF, 2'b00);

    for (int i = 0; i < 6; i++) qa[i] = 32'h8000_0200 + 32'(i * 8);
    n_acc   = 0;
    n_rsp   = 0;
    lo_seen = 1'b0;
    @(negedge aclk);
    araddr  = qa[0];
    arvalid = 1'b1;
    rready  = 1'b0;
    ar_f    = arready;
    for (int cyc = 0; cyc < 100 && n_rsp < 6; cyc++) begin
      @(negedge aclk);
      if (ar_f) begin
        n_acc++;
        if (n_acc < 6) araddr = qa[n_acc];
        else arvalid = 1'b0;
      end
      // four queued plus one held by the read engine
      if (!arready && arvalid && !lo_seen) begin
        lo_seen = 1'b1;
        chk("rq.acc_at_full", 64'(n_acc), 64'd5);
      end
      rready = (cyc >= 10);
      if (rvalid && rready) begin
        chk($sformatf("rq.rsp%0d", n_rsp), rdata, seed(qa[n_rsp]));
        n_rsp++;
      end
      ar_f = arvalid && arready;
    end
    chk("rq.full_seen", 64'(lo_seen), 64'd1);
    chk("rq.n_rsp", 64'(n_rsp), 64'd6);
    chk("rq.n_acc", 64'(n_acc), 64'd6);
    @(negedge aclk);
    rready = 1'b0;

    base = g_wr_cnt;
    @(negedge aclk);
    awaddr  = 32'h8000_0300;
    wdata   = 64'hA1A2_A3A4_A5A6_A7A8;
    wstrb   = 8'hFF;
    awvalid = 1'b1;
    wvalid  = 1'b1;
    bready  = 1'b0;
    @(negedge aclk);
    awaddr = 32'h8000_0308;
    wdata  = 64'hB1B2_B3B4_B5B6_B7B8;
    chk("b2.aw_held", 64'(awready), 64'd0);
    @(negedge aclk);
    chk("b2.first_b", 64'(bvalid), 64'd1);
    chk("b2.first_cnt", 64'(g_wr_cnt - base), 64'd1);
    @(negedge aclk);
    awvalid = 1'b0;
    wvalid  = 1'b0;
    chk("b2.second_held", 64'(awready), 64'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge aclk);
      chk($sformatf("b2.stall%0d", i),
        64'(g_wr_cnt - base), 64'd1);
    end
    chk("b2.b_hold", 64'(bvalid), 64'd1);
    bready = 1'b1;
    @(negedge aclk);
    chk("b2.hs_b", 64'(bvalid), 64'd0);
    chk("b2.hs_cnt", 64'(g_wr_cnt - base), 64'd1);
    @(negedge aclk);
    chk("b2.second_b", 64'(bvalid), 64'd1);
    chk("b2.second_cnt", 64'(g_wr_cnt - base), 64'd2);
    @(negedge aclk);
    bready = 1'b0;
    chk("b2.done", 64'(bvalid), 64'd0);
    rd_chk("b2.rb1", 32'h8000_0300,
      64'hA1A2_A3A4_A5A6_A7A8, 2'b00);
    rd_chk("b2.rb2", 32'h8000_0308,
      64'hB1B2_B3B4_B5B6_B7B8, 2'b00);

    base = g_rd_cnt;
    @(negedge aclk);
    araddr  = 32'h8000_0500;
    arvalid = 1'b1;
    rready  = 1'b0;
    @(negedge aclk);
    araddr = 32'h8000_0508;
    @(negedge aclk);
    araddr = 32'h8000_0510;
    @(negedge aclk);
    arvalid = 1'b0;
    chk("rst_mid.pre_rvalid", 64'(rvalid), 64'd0);
    aresetn = 1'b0;
    #1;
    chk("rst_mid.arready", 64'(arready), 64'd0);
    chk("rst_mid.rvalid", 64'(rvalid), 64'd0);
    @(negedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    chk("rst_mid.rel_ar", 64'(arready), 64'd1);
    chk("rst_mid.rel_aw", 64'(awready), 64'd1);
    chk("rst_mid.rel_w", 64'(wready), 64'd1);
    rready = 1'b1;
    seen   = 1'b0;
    repeat (12) begin
      @(negedge aclk);
      if (rvalid) seen = 1'b1;
    end
    rready = 1'b0;
    chk("rst_mid.no_rvalid", 64'(seen), 64'd0);
    chk("rst_mid.dpi", 64'(g_rd_cnt - base), 64'd0);
    rd_chk("post_rst", 32'h8000_0500,
      seed(32'h8000_0500), 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
      n_cmp, n_bad);
    $finish;
  end

endmodule
